// File: rtl/conv3x3_stream_pkg.sv
// Shared widths, geometry and helpers for the 3x3 streaming convolution stage.
package conv3x3_stream_pkg;

   localparam int IMG_W    = 8;
   localparam int IMG_H    = 8;
   localparam int CONV_LAT = 3;
   localparam int CNT_MAX  = IMG_W * IMG_H + 3;

   localparam int PIX_W  = 8;
   localparam int WGT_W  = 8;
   localparam int CONV_W = 8;
   localparam int PROD_W = PIX_W + WGT_W;
   localparam int ACC_W  = 20;
   localparam int TAPS   = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Half-LSB bias so the arithmetic shift rounds half up.
   function automatic int rnd_bias(input int shift);
      return (shift > 0) ? (1 << (shift - 1)) : 0;
   endfunction

   function automatic logic [CONV_W-1:0] sat_conv(input logic signed [ACC_W-1:0] a);
      localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (CONV_W - 1) - 1);
      localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (CONV_W - 1)));
      if (a > SAT_HI) return SAT_HI[CONV_W-1:0];
      if (a < SAT_LO) return SAT_LO[CONV_W-1:0];
      return a[CONV_W-1:0];
   endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// Product and sum/requantise stages of the 3x3 convolution (two registered stages).
module conv3x3_mac
   import conv3x3_stream_pkg::*;
#(
   parameter int SHIFT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    in_vld,
   input  logic [TAPS*PIX_W-1:0]   win,
   input  logic [TAPS*WGT_W-1:0]   w_flat,
   output logic                    out_vld,
   output logic [CONV_W-1:0]       conv
);

   localparam logic signed [ACC_W-1:0] RND = ACC_W'(rnd_bias(SHIFT));

   logic signed [PROD_W-1:0] prod [TAPS];
   logic                     prod_vld;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_vld <= 1'b0;
         for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      end else begin
         prod_vld <= in_vld && !clr;
         for (int k = 0; k < TAPS; k++)
            prod[k] <= PROD_W'($signed(win[k*PIX_W +: PIX_W])) *
                       PROD_W'($signed(w_flat[k*WGT_W +: WGT_W]));
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(prod[k]);
      acc = (sum + RND) >>> SHIFT;
   end

   // conv only moves with a valid result so it holds between windows.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld <= 1'b0;
         conv    <= '0;
      end else begin
         out_vld <= prod_vld && !clr;
         if (prod_vld && !clr) conv <= sat_conv(acc);
      end
   end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid convolution over one raster-ordered image, tagged with a frame cycle counter.
//
// state    | meaning
// ST_IDLE  | waiting for pixel 0, cnt=0
// ST_RUN   | consuming pixel cnt each cycle; a missing pixel aborts the frame
// ST_FLUSH | input closed, draining the pipeline until cnt=W*H+3
module conv3x3_stream
   import conv3x3_stream_pkg::*;
#(
   parameter int W     = IMG_W,
   parameter int H     = IMG_H,
   parameter int SHIFT = 4,
   parameter int CNT_W = $clog2(W * H + 4)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic [PIX_W-1:0]        pix,
   input  logic [TAPS*WGT_W-1:0]   w_flat,
   output logic                    out_vld,
   output logic [CNT_W-1:0]        cnt,
   output logic [CONV_W-1:0]       conv,
   output logic                    frame_done,
   output logic                    frame_err
);

   localparam int NPIX  = W * H;
   localparam int SR_D  = 2 * W + 2;
   localparam int POS_W = $clog2(((W > H) ? W : H) + 1);

   localparam logic [CNT_W-1:0] CNT_LASTPIX = CNT_W'(NPIX - 1);
   localparam logic [CNT_W-1:0] CNT_PREEND  = CNT_W'(NPIX + 2);
   localparam logic [CNT_W-1:0] CNT_END     = CNT_W'(NPIX + 3);

   state_t                  state;
   logic [POS_W-1:0]        col_q;
   logic [POS_W-1:0]        row_q;
   logic                    consume;
   logic                    gap;
   logic                    win_ok;
   logic [PIX_W-1:0]        sr   [SR_D];
   logic [PIX_W-1:0]        taps [TAPS];
   logic [TAPS*PIX_W-1:0]   win;
   logic                    win_vld;

   assign consume = ((state == ST_IDLE) || (state == ST_RUN)) && in_vld;
   assign gap     = (state == ST_RUN) && !in_vld;
   assign win_ok  = consume && (row_q >= POS_W'(2)) && (col_q >= POS_W'(2));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         in_rdy     <= 1'b1;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_vld) begin
                  state <= ST_RUN;
                  cnt   <= CNT_W'(1);
                  col_q <= POS_W'(1);
               end
            end
            ST_RUN: begin
               if (!in_vld) begin
                  state     <= ST_IDLE;
                  cnt       <= '0;
                  frame_err <= 1'b1;
                  col_q     <= '0;
                  row_q     <= '0;
               end else if (cnt == CNT_LASTPIX) begin
                  state  <= ST_FLUSH;
                  cnt    <= cnt + CNT_W'(1);
                  in_rdy <= 1'b0;
                  col_q  <= '0;
                  row_q  <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (col_q == POS_W'(W - 1)) begin
                     col_q <= '0;
                     row_q <= row_q + POS_W'(1);
                  end else begin
                     col_q <= col_q + POS_W'(1);
                  end
               end
            end
            ST_FLUSH: begin
               if (cnt == CNT_END) begin
                  state  <= ST_IDLE;
                  cnt    <= '0;
                  in_rdy <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_PREEND) frame_done <= 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               cnt    <= '0;
               in_rdy <= 1'b1;
            end
         endcase
      end
   end

   // The incoming pixel is the newest tap, so the window register is stage 1.
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      localparam int D = (2 - k / 3) * W + (2 - k % 3);
      if (D == 0) begin : g_new
         assign taps[k] = pix;
      end else begin : g_old
         assign taps[k] = sr[D-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SR_D; i++) sr[i] <= '0;
         win     <= '0;
         win_vld <= 1'b0;
      end else begin
         win_vld <= win_ok;
         if (consume) begin
            sr[0] <= pix;
            for (int i = 1; i < SR_D; i++) sr[i] <= sr[i-1];
            for (int k = 0; k < TAPS; k++) win[k*PIX_W +: PIX_W] <= taps[k];
         end
      end
   end

   conv3x3_mac #(
      .SHIFT (SHIFT)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr     (gap),
      .in_vld  (win_vld),
      .win     (win),
      .w_flat  (w_flat),
      .out_vld (out_vld),
      .conv    (conv)
   );

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised bench for conv3x3_stream: three instances (SHIFT 0/2/4) against a direct-convolution model.
module tb_conv3x3_stream;
   import conv3x3_stream_pkg::*;

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NDUT  = 3;
   localparam int CNT_W = $clog2(NPIX + 4);

   logic                clk = 1'b0;
   logic                rst;
   logic                in_vld;
   logic [7:0]          pix;
   logic [71:0]         w_flat;
   logic                in_rdy_a  [NDUT];
   logic                out_vld_a [NDUT];
   logic [CNT_W-1:0]    cnt_a     [NDUT];
   logic [7:0]          conv_a    [NDUT];
   logic                done_a    [NDUT];
   logic                err_a     [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      conv3x3_stream #(
         .W     (IMG_W),
         .H     (IMG_H),
         .SHIFT (2 * g),
         .CNT_W (CNT_W)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .in_vld     (in_vld),
         .in_rdy     (in_rdy_a[g]),
         .pix        (pix),
         .w_flat     (w_flat),
         .out_vld    (out_vld_a[g]),
         .cnt        (cnt_a[g]),
         .conv       (conv_a[g]),
         .frame_done (done_a[g]),
         .frame_err  (err_a[g])
      );
   end

   int img   [NPIX];
   int wt    [9];
   bit exp_v [CNT_MAX+1];
   int exp_c [NDUT][CNT_MAX+1];
   int cap   [NDUT][CNT_MAX+1];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Round half up, then clamp to the signed 8-bit range.
   function automatic int requant(input int sum, input int sh);
      int den, num, q;
      den = 1 << sh;
      num = sum + den / 2;
      q = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   task automatic build_model();
      int sum, k;
      for (int i = 0; i <= CNT_MAX; i++) begin
         exp_v[i] = 1'b0;
         for (int d = 0; d < NDUT; d++) exp_c[d][i] = 0;
      end
      for (int r = 2; r < IMG_H; r++) begin
         for (int c = 2; c < IMG_W; c++) begin
            sum = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  sum += img[(r - 2 + i) * IMG_W + (c - 2 + j)] * wt[i * 3 + j];
            k = r * IMG_W + c + CONV_LAT;
            exp_v[k] = 1'b1;
            for (int d = 0; d < NDUT; d++) exp_c[d][k] = requant(sum, 2 * d);
         end
      end
      for (int i = 0; i < 9; i++) w_flat[i*8 +: 8] = 8'(wt[i]);
   endtask

   task automatic fill_img(input int v);
      for (int p = 0; p < NPIX; p++) img[p] = v;
   endtask

   task automatic rand_frame();
      for (int p = 0; p < NPIX; p++) img[p] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 9; i++) wt[i] = int'($urandom_range(0, 255)) - 128;
   endtask

   task automatic check_cycle(input int k);
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("cnt d%0d k%0d", d, k), int'(cnt_a[d]), k);
         chk($sformatf("in_rdy d%0d k%0d", d, k), int'(in_rdy_a[d]), (k < NPIX) ? 1 : 0);
         chk($sformatf("out_vld d%0d k%0d", d, k), int'(out_vld_a[d]), int'(exp_v[k]));
         if (exp_v[k])
            chk($sformatf("conv d%0d k%0d", d, k), int'($signed(conv_a[d])), exp_c[d][k]);
         chk($sformatf("done d%0d k%0d", d, k), int'(done_a[d]), (k == CNT_MAX) ? 1 : 0);
         chk($sformatf("err d%0d k%0d", d, k), int'(err_a[d]), 0);
         cap[d][k] = int'($signed(conv_a[d]));
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s cnt d%0d", tag, d), int'(cnt_a[d]), 0);
            chk($sformatf("%s in_rdy d%0d", tag, d), int'(in_rdy_a[d]), 1);
            chk($sformatf("%s out_vld d%0d", tag, d), int'(out_vld_a[d]), 0);
            chk($sformatf("%s done d%0d", tag, d), int'(done_a[d]), 0);
            chk($sformatf("%s err d%0d", tag, d), int'(err_a[d]), 0);
         end
         in_vld = 1'b0;
      end
   endtask

   // kind: 0 full frame, 1 stream gap at cycle abort_k, 2 reset at cycle abort_k
   task automatic run_frame(input int abort_k, input int kind, input bit b2b);
      int nv [NDUT];
      for (int d = 0; d < NDUT; d++) nv[d] = 0;
      for (int k = 0; k <= CNT_MAX; k++) begin
         @(negedge clk);
         check_cycle(k);
         for (int d = 0; d < NDUT; d++) if (out_vld_a[d]) nv[d]++;
         if (kind != 0 && k == abort_k) begin
            if (kind == 1) in_vld = 1'b0;
            else begin
               rst    = 1'b1;
               in_vld = 1'b1;
            end
            pix = 8'($urandom);
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
               chk($sformatf("abort err d%0d", d), int'(err_a[d]), (kind == 1) ? 1 : 0);
               chk($sformatf("abort cnt d%0d", d), int'(cnt_a[d]), 0);
               chk($sformatf("abort out_vld d%0d", d), int'(out_vld_a[d]), 0);
               chk($sformatf("abort done d%0d", d), int'(done_a[d]), 0);
               chk($sformatf("abort in_rdy d%0d", d), int'(in_rdy_a[d]), 1);
               if (kind == 2) chk($sformatf("reset conv d%0d", d), int'(conv_a[d]), 0);
            end
            rst    = 1'b0;
            in_vld = 1'b0;
            idle(4, "post-abort");
            return;
         end
         if (k < NPIX) begin
            in_vld = 1'b1;
            pix    = 8'(img[k]);
         end else begin
            in_vld = b2b ? 1'b1 : 1'($urandom & 1);
            pix    = 8'($urandom);
         end
      end
      for (int d = 0; d < NDUT; d++) chk($sformatf("vld count d%0d", d), nv[d], 36);
      if (!b2b) idle(2, "idle");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int saved_img [NPIX];
      int saved_wt  [9];
      rst    = 1'b1;
      in_vld = 1'b0;
      pix    = '0;
      w_flat = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("rst cnt d%0d", d), int'(cnt_a[d]), 0);
         chk($sformatf("rst out_vld d%0d", d), int'(out_vld_a[d]), 0);
         chk($sformatf("rst conv d%0d", d), int'(conv_a[d]), 0);
         chk($sformatf("rst in_rdy d%0d", d), int'(in_rdy_a[d]), 1);
         chk($sformatf("rst done d%0d", d), int'(done_a[d]), 0);
         chk($sformatf("rst err d%0d", d), int'(err_a[d]), 0);
      end
      rst = 1'b0;
      idle(2, "start");

      // identity kernel, pix = p
      wt = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      for (int p = 0; p < NPIX; p++) img[p] = p;
      build_model();
      run_frame(0, 0, 1'b0);
      chk("identity cnt21", cap[0][21], 9);
      chk("identity cnt22", cap[0][22], 10);
      chk("identity cnt66", cap[0][66], 54);

      // saturation
      wt = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
      fill_img(100);
      build_model();
      run_frame(0, 0, 1'b0);
      chk("sat pos", cap[0][30], 127);
      fill_img(-100);
      build_model();
      run_frame(0, 0, 1'b0);
      chk("sat neg", cap[0][30], -128);

      // rounding at SHIFT=2, frames back-to-back through flush
      fill_img(1);
      build_model();
      run_frame(0, 0, 1'b1);
      chk("round +1", cap[1][40], 2);
      fill_img(3);
      build_model();
      run_frame(0, 0, 1'b1);
      chk("round +3", cap[1][40], 7);
      fill_img(-1);
      build_model();
      run_frame(0, 0, 1'b0);
      chk("round -1", cap[1][40], -2);

      // stream gap, then a normal frame
      rand_frame();
      build_model();
      run_frame(30, 1, 1'b0);
      rand_frame();
      build_model();
      run_frame(0, 0, 1'b0);

      // reset mid-frame, then the same frame to completion
      rand_frame();
      build_model();
      run_frame(40, 2, 1'b0);
      run_frame(0, 0, 1'b0);

      // identical frame twice back-to-back
      rand_frame();
      saved_img = img;
      saved_wt  = wt;
      build_model();
      run_frame(0, 0, 1'b1);
      img = saved_img;
      wt  = saved_wt;
      build_model();
      run_frame(0, 0, 1'b0);

      for (int f = 0; f < 4; f++) begin
         rand_frame();
         build_model();
         run_frame(0, 0, 1'($urandom & 1));
      end
      idle(2, "end");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
